// File: rtl/spy_tdc_pkg.sv
// Shared types and helpers for the spy_tdc time-to-digital sampler.
// Optional bubble filter is enabled by defining SPY_TDC_BUBBLE_FIX_EN.
package spy_tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_CAPTURE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Bits needed to hold a reading in 0..taps.
    function automatic int cnt_width(input int taps);
        return $clog2(taps + 1);
    endfunction

    // Cell i has seen i+1 inversions, so even taps are inverted relative to launch.
    function automatic logic tap_mask_bit(input int idx);
        return ((idx % 2) == 0);
    endfunction

endpackage

// File: rtl/spy_tdc_decode.sv
// Normalises a captured tap vector and counts the prefix matching the launch level.
// Latency: combinational. Backpressure: none.
// With SPY_TDC_BUBBLE_FIX_EN a 3-tap majority filter removes single-tap bubbles first.
module spy_tdc_decode
    import spy_tdc_pkg::*;
#(
    parameter int TAPS  = 50,
    parameter int CNT_W = cnt_width(TAPS)
) (
    input  logic [TAPS-1:0]  tap_dat,
    input  logic             launch_lvl,
    output logic [CNT_W-1:0] reading
);

    logic [TAPS-1:0] norm;
    logic [TAPS-1:0] dec;

    always_comb begin
        norm = '0;
        for (int i = 0; i < TAPS; i++) begin
            norm[i] = tap_dat[i] ^ tap_mask_bit(i);
        end
    end

`ifdef SPY_TDC_BUBBLE_FIX_EN
    // At the ends the missing neighbour equals the tap itself, so the majority is the tap.
    always_comb begin
        dec           = norm;
        dec[0]        = norm[0];
        dec[TAPS-1]   = norm[TAPS-1];
        for (int i = 1; i < TAPS - 1; i++) begin
            dec[i] = (norm[i-1] & norm[i]) | (norm[i-1] & norm[i+1]) | (norm[i] & norm[i+1]);
        end
    end
`else
    assign dec = norm;
`endif

    always_comb begin
        logic in_prefix;
        reading   = '0;
        in_prefix = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            if (in_prefix && (dec[i] == launch_lvl)) begin
                reading = reading + CNT_W'(1);
            end else begin
                in_prefix = 1'b0;
            end
        end
    end

endmodule

// File: rtl/spy_tdc_delay_cell.sv
// Single inverting delay cell; kept through synthesis so the chain length is preserved.
// Latency: combinational. Backpressure: none.
// Used by spy_tdc_sampler as one link of the delay chain.
module spy_tdc_delay_cell (
    input  logic a,
    output logic y
);

    (* keep = "true", dont_touch = "true" *) logic inv_out;

    assign inv_out = ~a;
    assign y       = inv_out;

endmodule

// File: rtl/spy_tdc_sampler.sv
// Delay-chain TDC: launch, capture, decode and accumulate N samples, then present sum and last reading.
// Latency: 3 cycles per sample, 3*N cycles from accept to res_valid.
// Backpressure: result held in DONE until res_valid & res_ready; start ignored outside IDLE. Macro: SPY_TDC_BUBBLE_FIX_EN.
module spy_tdc_sampler
    import spy_tdc_pkg::*;
#(
    parameter int TAPS   = 50,
    parameter int SAMP_W = 8,
    parameter int CNT_W  = cnt_width(TAPS),
    parameter int ACC_W  = CNT_W + SAMP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SAMP_W-1:0] n_samples,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic [CNT_W-1:0]  res_last,
    output logic [TAPS-1:0]   taps_dbg
);

    state_t             state_q,  state_d;
    logic               launch_q, launch_d;
    logic [TAPS-1:0]    tap_q,    tap_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]   last_q,   last_d;
    logic [SAMP_W-1:0]  cnt_q,    cnt_d;
    logic [SAMP_W-1:0]  nsamp_q,  nsamp_d;

    logic [TAPS-1:0]    chain_out;
    logic [CNT_W-1:0]   reading;
    logic [SAMP_W:0]    cnt_inc;

    // Each cell is its own net so the chain is a straight line, not a self-referencing vector.
    for (genvar g = 0; g < TAPS; g++) begin : g_cell
        logic cell_in;
        logic cell_out;
        if (g == 0) begin : g_first
            assign cell_in = launch_q;
        end else begin : g_next
            assign cell_in = g_cell[g-1].cell_out;
        end
        spy_tdc_delay_cell u_cell (
            .a (cell_in),
            .y (cell_out)
        );
        assign chain_out[g] = cell_out;
    end

    spy_tdc_decode #(
        .TAPS  (TAPS),
        .CNT_W (CNT_W)
    ) u_decode (
        .tap_dat    (tap_q),
        .launch_lvl (launch_q),
        .reading    (reading)
    );

    assign cnt_inc = {1'b0, cnt_q} + (SAMP_W + 1)'(1);

    always_comb begin
        state_d  = state_q;
        launch_d = launch_q;
        tap_d    = tap_q;
        acc_d    = acc_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        nsamp_d  = nsamp_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nsamp_d = (n_samples == '0) ? SAMP_W'(1) : n_samples;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                launch_d = ~launch_q;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                tap_d   = chain_out;
                state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_d   = acc_q + ACC_W'(reading);
                last_d  = reading;
                cnt_d   = cnt_inc[SAMP_W-1:0];
                state_d = (cnt_inc == {1'b0, nsamp_q}) ? ST_DONE : ST_LAUNCH;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            tap_q    <= '0;
            acc_q    <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            nsamp_q  <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            tap_q    <= tap_d;
            acc_q    <= acc_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            nsamp_q  <= nsamp_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_sum   = acc_q;
    assign res_last  = last_q;
    assign taps_dbg  = tap_q;

endmodule
